vitals_frame_parser: RTL and testbench
======================================

Name: vitals_frame_parser

Overview:
- Parametrised successor to the hard-coded SAT/OX/TEMP value register feeding the LCD.
- Consumes bytes from the bluetooth UART receiver and parses checksummed frames carrying NUM_CH 8-bit vital-sign channels (channel 0 SAT, 1 OX, 2 TEMP, further channels spare).
- Publishes channels to the display path on a parametrised refresh tick, replacing the free-running frequency divider.
- Adds inter-byte timeout, error counting and a stale-data flag.

Parameters:
- NUM_CH, 3: number of 8-bit data channels per frame (1..16).
- SYNC_BYTE, 8'hAA: frame start marker.
- REFRESH_DIV, 50_000_000: CLOCK_50 cycles per refresh tick (2..2^27).
- TIMEOUT_CYC, 1_000_000: maximum idle cycles between bytes inside a frame.
- STALE_TICKS, 4: refresh ticks without a good frame before stale asserts.
- ERR_W, 8: error counter width.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- ch_data  out  NUM_CH*8  published channels; channel k in bits [8k+7:8k].
- frame_ok  out  1  one-cycle pulse on each accepted frame.
- chk_err  out  1  one-cycle pulse on checksum mismatch.
- tmo_err  out  1  one-cycle pulse on inter-byte timeout.
- err_count  out  ERR_W  saturating count of chk_err plus tmo_err events.
- stale  out  1  high when published data is out of date.
- refresh_tick  out  1  one-cycle refresh pulse (drives LCD update).

Behaviour:
- Reset (reset=0, async): all outputs 0 except stale=1. FSM goes to IDLE; buffer, shadow, counters and the shadow_new flag clear.
- Frame format: SYNC_BYTE, then NUM_CH data bytes (ch0 first), then CHK = 8-bit mod-256 sum of the data bytes.
- IDLE:
  - rx_valid with SYNC_BYTE -> DATA, idx=0.
  - Any other byte is ignored silently (no error).
- DATA: each rx_valid stores rx_data into buf[idx], adds it to the running sum and increments idx. The byte at idx=NUM_CH-1 moves the FSM to CHK. A SYNC_BYTE value in DATA is ordinary data; there is no resync.
- CHK, on rx_valid:
  - rx_data==sum: shadow<=buf, shadow_new<=1, frame_ok pulses the cycle after the CHK byte strobe.
  - Otherwise: chk_err pulses with the same timing and shadow is unchanged.
  - Either way the FSM returns to IDLE.
- Timeout:
  - The counter clears on every rx_valid and counts while in DATA or CHK.
  - On reaching TIMEOUT_CYC: FSM -> IDLE, tmo_err pulses for one cycle, partial buffer is discarded.
- err_count: increments by 1 on each chk_err or tmo_err and saturates at all-ones. The two cannot coincide.
- Refresh tick: refresh_tick pulses once every REFRESH_DIV cycles. The first pulse comes REFRESH_DIV cycles after reset release.
- On refresh_tick with shadow_new=1: ch_data<=shadow, shadow_new<=0.
- Tick and frame commit in the same cycle: the tick publishes the pre-commit shadow (registered semantics). The new frame publishes on the next tick.
- Stale logic:
  - stale_cnt counts refresh ticks and clears on each accepted frame.
  - stale=1 when stale_cnt>=STALE_TICKS, or when no frame has been accepted since reset.
  - stale deasserts on the tick that publishes the first good frame.
  - stale_cnt saturates at STALE_TICKS.
- Latency: CHK strobe -> frame_ok takes 1 cycle. CHK strobe -> ch_data update happens at the next refresh tick, at least 1 cycle later.
- Sum width: 8-bit wrap, with carries discarded.

Decomposition:
- Package vitals_pkg holds:
  - the FSM state enum (IDLE, DATA, CHK);
  - channel index constants CH_SAT=0, CH_OX=1, CH_TEMP=2;
  - the default SYNC_BYTE.
- One sub-module, refresh_tick_gen: parametrised REFRESH_DIV counter with async active-low reset producing the one-cycle tick. It replaces the old divider for this path.

Test Plan (bench uses REFRESH_DIV=20, TIMEOUT_CYC=50, STALE_TICKS=2, NUM_CH=3):
1. Send AA 23 3E 61 C2 (35,62,97, sum 0xC2): frame_ok 1 cycle after C2. At the next tick ch_data=0x613E23 and stale drops to 0.
2. Send AA 23 3E 61 C3: chk_err pulses, err_count=1, ch_data keeps its prior value, no frame_ok.
3. Send AA 23, then 60 idle cycles: tmo_err pulses at cycle 50 after 0x23 and err_count increments. A following good frame is accepted normally.
4. Send 55 AA 01 02 03 06: the leading 0x55 is ignored and the frame is accepted, ch_data=0x030201. An AA inside data (AA AA 00 00 AA) is accepted as data 0xAA,0,0.
5. Align the CHK byte of frame 2 with a refresh tick: that tick publishes frame 1 and the next tick publishes frame 2. After 2 ticks with no frames stale=1.
6. Assert reset mid-DATA: all outputs go to their reset values immediately and stale=1. Force 2^ERR_W+3 checksum errors: err_count holds at all-ones.

Source files
------------

// File: rtl/vitals_pkg.sv
// Shared definitions for the vitals frame parser: FSM states, channel map, default sync marker.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package vitals_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CHK  = 2'd2
    } state_t;

    // Channel positions inside a frame / inside ch_data
    localparam int CH_SAT  = 0;
    localparam int CH_OX   = 1;
    localparam int CH_TEMP = 2;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hAA;

endpackage

// File: rtl/refresh_tick_gen.sv
// Refresh tick generator: one-cycle pulse every REFRESH_DIV clocks.
// Latency: first pulse REFRESH_DIV cycles after reset release, then period REFRESH_DIV.
// Backpressure: none, free running.
// Ports: CLOCK_50 clock, reset async active-low, tick one-cycle registered pulse.
module refresh_tick_gen #(
    parameter int REFRESH_DIV = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            if (cnt == LAST) cnt <= '0;
            else             cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vitals_frame_parser.sv
// Vitals frame parser: parses SYNC + NUM_CH data + mod-256 checksum frames from the UART, publishes on refresh ticks.
// Latency: CHK byte -> frame_ok/chk_err 1 cycle; accepted frame -> ch_data at the next refresh tick.
// Backpressure: none; every rx_valid byte is consumed, idle gaps inside a frame beyond TIMEOUT_CYC abort it.
// Ports: CLOCK_50/reset; rx_data/rx_valid byte stream in; ch_data published channels (ch k at [8k+7:8k]);
//        frame_ok/chk_err/tmo_err event pulses; err_count saturating error total; stale; refresh_tick.
module vitals_frame_parser
    import vitals_pkg::*;
#(
    parameter int         NUM_CH      = 3,
    parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter int         REFRESH_DIV = 50_000_000,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter int         STALE_TICKS = 4,
    parameter int         ERR_W       = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [NUM_CH*8-1:0]   ch_data,
    output logic                  frame_ok,
    output logic                  chk_err,
    output logic                  tmo_err,
    output logic [ERR_W-1:0]      err_count,
    output logic                  stale,
    output logic                  refresh_tick
);

    localparam int IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam int STW = $clog2(STALE_TICKS + 1);

    localparam logic [IW-1:0]  IDX_LAST  = IW'(NUM_CH - 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [STW-1:0] STALE_MAX = STW'(STALE_TICKS);

    state_t               state;
    logic [IW-1:0]        idx;
    logic [7:0]           sum;
    logic [NUM_CH*8-1:0]  frame_buf;
    logic [NUM_CH*8-1:0]  shadow;
    logic                 shadow_new;
    logic [TW-1:0]        tmo_cnt;
    logic [STW-1:0]       stale_cnt;
    logic                 published;

    logic tick;
    logic chk_pass;
    logic chk_fail;
    logic tmo_hit;

    refresh_tick_gen #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_tick (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .tick    (tick)
    );

    assign refresh_tick = tick;

    // A byte arriving in the same cycle as the timeout limit keeps the frame alive.
    assign chk_pass = (state == CHK) && rx_valid && (rx_data == sum);
    assign chk_fail = (state == CHK) && rx_valid && (rx_data != sum);
    assign tmo_hit  = (state != IDLE) && !rx_valid && (tmo_cnt == TMO_LAST);

    // Stale until the first good frame is actually shown, then after STALE_TICKS quiet ticks.
    assign stale = !published || (stale_cnt >= STALE_MAX);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            sum        <= '0;
            frame_buf  <= '0;
            shadow     <= '0;
            shadow_new <= 1'b0;
            tmo_cnt    <= '0;
            stale_cnt  <= '0;
            published  <= 1'b0;
            ch_data    <= '0;
            frame_ok   <= 1'b0;
            chk_err    <= 1'b0;
            tmo_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            frame_ok <= chk_pass;
            chk_err  <= chk_fail;
            tmo_err  <= tmo_hit;

            if ((chk_fail || tmo_hit) && (err_count != '1))
                err_count <= err_count + ERR_W'(1);

            if (rx_valid || state == IDLE) tmo_cnt <= '0;
            else                           tmo_cnt <= tmo_cnt + TW'(1);

            // Publish uses the shadow as it stood before this edge; a commit on the
            // same edge re-arms shadow_new below so it goes out on the following tick.
            if (tick && shadow_new) begin
                ch_data    <= shadow;
                shadow_new <= 1'b0;
                published  <= 1'b1;
            end
            if (tick && stale_cnt < STALE_MAX)
                stale_cnt <= stale_cnt + STW'(1);

            case (state)
                IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state <= DATA;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        frame_buf[8*int'(idx) +: 8] <= rx_data;
                        sum <= sum + rx_data;
                        idx <= idx + IW'(1);
                        if (idx == IDX_LAST) state <= CHK;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                    end
                end
                CHK: begin
                    if (rx_valid) begin
                        state <= IDLE;
                        if (chk_pass) begin
                            shadow     <= frame_buf;
                            shadow_new <= 1'b1;
                            stale_cnt  <= '0;
                        end
                    end else if (tmo_hit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vitals_frame_parser.sv
module tb_vitals_frame_parser;

    logic        CLOCK_50;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [23:0] ch_data;
    logic        frame_ok;
    logic        chk_err;
    logic        tmo_err;
    logic [7:0]  err_count;
    logic        stale;
    logic        refresh_tick;

    int total = 0;
    int bad   = 0;

    vitals_frame_parser #(
        .NUM_CH     (3),
        .SYNC_BYTE  (8'hAA),
        .REFRESH_DIV(20),
        .TIMEOUT_CYC(50),
        .STALE_TICKS(2),
        .ERR_W      (8)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .ch_data     (ch_data),
        .frame_ok    (frame_ok),
        .chk_err     (chk_err),
        .tmo_err     (tmo_err),
        .err_count   (err_count),
        .stale       (stale),
        .refresh_tick(refresh_tick)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller sits at a negedge; byte is sampled by the next posedge; returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLOCK_50);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] c);
        send_byte(8'hAA);
        send_byte(d0);
        send_byte(d1);
        send_byte(d2);
        send_byte(c);
    endtask

    // Returns at the negedge where refresh_tick is seen high; n = negedges waited.
    task automatic wait_tick(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLOCK_50);
            n++;
            if (refresh_tick) seen = 1'b1;
        end
        if (!seen) check_eq("tick_wait_expired", 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        int hit;

        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        check_eq("rst_ch_data", ch_data, 0);
        check_eq("rst_frame_ok", frame_ok, 0);
        check_eq("rst_chk_err", chk_err, 0);
        check_eq("rst_tmo_err", tmo_err, 0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_stale", stale, 1);
        check_eq("rst_tick", refresh_tick, 0);
        @(negedge CLOCK_50);
        reset = 1'b1;

        // Tick timing: first pulse REFRESH_DIV cycles after release, then every REFRESH_DIV
        wait_tick(n);
        check_eq("first_tick", n, 20);
        wait_tick(n);
        check_eq("tick_period", n, 20);

        // 1: good frame
        send_frame(8'h23, 8'h3E, 8'h61, 8'hC2);
        check_eq("t1_frame_ok", frame_ok, 1);
        check_eq("t1_stale_before", stale, 1);
        wait_tick(n);
        @(negedge CLOCK_50);
        check_eq("t1_ch_data", ch_data, 24'h613E23);
        check_eq("t1_stale", stale, 0);

        // 2: bad checksum
        send_frame(8'h23, 8'h3E, 8'h61, 8'hC3);
        check_eq("t2_chk_err", chk_err, 1);
        check_eq("t2_frame_ok", frame_ok, 0);
        check_eq("t2_err_count", err_count, 1);
        wait_tick(n);
        @(negedge CLOCK_50);
        check_eq("t2_ch_data", ch_data, 24'h613E23);

        // 3: inter-byte timeout
        send_byte(8'hAA);
        send_byte(8'h23);
        hit = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLOCK_50);
            if (tmo_err && hit == 0) hit = k;
        end
        check_eq("t3_tmo_cycle", hit, 50);
        check_eq("t3_err_count", err_count, 2);
        send_frame(8'h10, 8'h20, 8'h30, 8'h60);
        check_eq("t3_frame_ok", frame_ok, 1);

        // 4: junk before sync ignored; sync value inside data is plain data
        send_byte(8'h55);
        check_eq("t4_no_err", err_count, 2);
        send_frame(8'h01, 8'h02, 8'h03, 8'h06);
        check_eq("t4_frame_ok", frame_ok, 1);
        wait_tick(n);
        @(negedge CLOCK_50);
        check_eq("t4_ch_data", ch_data, 24'h030201);
        send_frame(8'hAA, 8'h00, 8'h00, 8'hAA);
        check_eq("t4_aa_frame_ok", frame_ok, 1);
        wait_tick(n);
        @(negedge CLOCK_50);
        check_eq("t4_aa_ch_data", ch_data, 24'h0000AA);

        // 5: CHK of frame 2 coincides with a tick
        wait_tick(n);
        send_frame(8'h11, 8'h22, 8'h33, 8'h66);
        check_eq("t5_f1_ok", frame_ok, 1);
        send_byte(8'hAA);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        wait_tick(n);
        send_byte(8'hFF);
        check_eq("t5_f2_ok", frame_ok, 1);
        check_eq("t5_tick_pub_f1", ch_data, 24'h332211);
        wait_tick(n);
        @(negedge CLOCK_50);
        check_eq("t5_next_pub_f2", ch_data, 24'h665544);
        check_eq("t5_stale_fresh", stale, 0);
        wait_tick(n);
        @(negedge CLOCK_50);
        check_eq("t5_stale_aged", stale, 1);

        // 6: async reset mid-DATA, then error counter saturation
        send_byte(8'hAA);
        send_byte(8'h01);
        #3 reset = 1'b0;
        #1;
        check_eq("t6_ch_data", ch_data, 0);
        check_eq("t6_err_count", err_count, 0);
        check_eq("t6_stale", stale, 1);
        check_eq("t6_frame_ok", frame_ok, 0);
        check_eq("t6_tick", refresh_tick, 0);
        @(negedge CLOCK_50);
        reset = 1'b1;
        for (int i = 0; i < 255; i++) send_frame(8'h01, 8'h02, 8'h03, 8'h00);
        check_eq("t6_err_255", err_count, 8'hFF);
        for (int i = 0; i < 4; i++) send_frame(8'h01, 8'h02, 8'h03, 8'h00);
        check_eq("t6_err_sat", err_count, 8'hFF);
        check_eq("t6_chk_err", chk_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
